// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Registered, handshaked write-back stage of the 5-stage pipeline. One entry
// per cycle is taken from MEM/WB, its result source is selected (ALU, memory
// load, link address or Booth multiplier product) and the register-file write
// port is driven one cycle after acceptance. A multiplier entry whose product
// is not yet available parks the stage in WAIT_MUL until mul_done arrives.
//
// Optional feature macro: LOAD_EXT_EN
//   defined   : the MEM source is the size/sign-extended load data
//   undefined : the MEM source is read_data unchanged; load_size and
//               load_signed are ignored
//
// Parameters
//   DATA_W  datapath width (16 or more, multiple of 8)
//   ADDR_W  register-file address width
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_valid        MEM/WB entry valid
//   in_ready        stage can accept an entry this cycle
//   wb_sel          result source: 0 ALU, 1 MEM, 2 LINK, 3 MUL
//   reg_write, rd   entry writes register rd
//   alu_result      ALU result
//   read_data       data-memory load data
//   pc_plus4        link address
//   load_size       0 word, 1 half, 2 byte (LOAD_EXT_EN only)
//   load_signed     sign-extend sub-word loads (LOAD_EXT_EN only)
//   mul_done        Booth product valid (1-cycle pulse)
//   mul_result      low DATA_W bits of the product
//   rf_we/rf_waddr/rf_wdata  register-file write port (registered)
//   fwd_valid/fwd_addr       forwarding view for the hazard unit
//   stall           NOT in_ready
//   fsm_state       debug view of the FSM (0 RUN, 1 WAIT_MUL)
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        wb_sel,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [1:0]        load_size,
    input  logic              load_signed,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_result,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic              stall,
    output logic              fsm_state
);

    // Handshake: an entry transfers on a cycle where in_valid && in_ready are
    // both high at the rising edge. The producer must hold its entry stable
    // while in_valid is high and in_ready is low; in_ready never depends on
    // in_valid, so there is no combinational loop through the handshake.

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;
    localparam logic [1:0] SEL_MUL  = 2'd3;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MUL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    // Write port registers and their next values
    logic              rf_we_next;
    logic [ADDR_W-1:0] rf_waddr_next;
    logic [DATA_W-1:0] rf_wdata_next;

    // Destination of a multiplier entry whose product is still outstanding
    logic              pend_write;
    logic [ADDR_W-1:0] pend_rd;
    logic              pend_write_next;
    logic [ADDR_W-1:0] pend_rd_next;

    logic              accept;
    logic              entry_write;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] sel_data;

    // ------------------------------------------------------------------------
    // Memory source
    // ------------------------------------------------------------------------
`ifdef LOAD_EXT_EN
    always_comb begin
        mem_data = read_data;
        case (load_size)
            2'd1: mem_data = {{(DATA_W-16){load_signed & read_data[15]}},
                              read_data[15:0]};
            2'd2: mem_data = {{(DATA_W-8){load_signed & read_data[7]}},
                              read_data[7:0]};
            default: mem_data = read_data;   // word, and the reserved size 3
        endcase
    end
`else
    // Size and sign are only meaningful with load extension; they are folded
    // into a sink so the unused inputs are deliberate.
    logic load_ctrl_unused;
    assign load_ctrl_unused = ^{load_size, load_signed};
    assign mem_data         = read_data;
`endif

    // ------------------------------------------------------------------------
    // Result select and write qualification
    // ------------------------------------------------------------------------
    always_comb begin
        sel_data = alu_result;
        case (wb_sel)
            SEL_ALU:  sel_data = alu_result;
            SEL_MEM:  sel_data = mem_data;
            SEL_LINK: sel_data = pc_plus4;
            SEL_MUL:  sel_data = mul_result;
            default:  sel_data = alu_result;
        endcase
    end

    // r0 is hard-wired to zero, so any write aimed at it is dropped here.
    assign entry_write = reg_write && (rd != '0);

    assign in_ready  = (state == RUN);
    assign stall     = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign fsm_state = state;

    // ------------------------------------------------------------------------
    // FSM: next state and next register values
    // ------------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        rf_we_next      = 1'b0;
        rf_waddr_next   = rf_waddr;
        rf_wdata_next   = rf_wdata;
        pend_write_next = pend_write;
        pend_rd_next    = pend_rd;

        case (state)
            RUN: begin
                // mul_done without an accepted MUL entry is a stray pulse and
                // is ignored here.
                if (accept) begin
                    if ((wb_sel == SEL_MUL) && !mul_done) begin
                        pend_write_next = entry_write;
                        pend_rd_next    = rd;
                        state_next      = WAIT_MUL;
                    end else begin
                        rf_we_next    = entry_write;
                        rf_waddr_next = rd;
                        rf_wdata_next = sel_data;
                    end
                end
            end

            WAIT_MUL: begin
                if (mul_done) begin
                    rf_we_next      = pend_write;
                    rf_waddr_next   = pend_rd;
                    rf_wdata_next   = mul_result;
                    pend_write_next = 1'b0;
                    state_next      = RUN;
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and write port registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            pend_write <= 1'b0;
            pend_rd    <= '0;
        end else begin
            state      <= state_next;
            rf_we      <= rf_we_next;
            rf_waddr   <= rf_waddr_next;
            rf_wdata   <= rf_wdata_next;
            pend_write <= pend_write_next;
            pend_rd    <= pend_rd_next;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding view. While a product is outstanding the destination is
    // advertised early so the hazard unit stalls any reader of it; otherwise
    // the write that is on the register-file port this cycle is shown.
    // ------------------------------------------------------------------------
    always_comb begin
        if (state == WAIT_MUL) begin
            fwd_valid = pend_write;
            fwd_addr  = pend_rd;
        end else begin
            fwd_valid = rf_we;
            fwd_addr  = rf_waddr;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed bench for writeback_stage. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        wb_sel;
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] pc_plus4;
    logic [1:0]        load_size;
    logic              load_signed;
    logic              mul_done;
    logic [DATA_W-1:0] mul_result;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic              stall;
    logic              fsm_state;

    int errors = 0;
    int checks = 0;

    writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wb_sel      (wb_sel),
        .reg_write   (reg_write),
        .rd          (rd),
        .alu_result  (alu_result),
        .read_data   (read_data),
        .pc_plus4    (pc_plus4),
        .load_size   (load_size),
        .load_signed (load_signed),
        .mul_done    (mul_done),
        .mul_result  (mul_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .stall       (stall),
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one clock and land 1 unit past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input logic [1:0] sel, input logic rw,
                               input logic [ADDR_W-1:0] dst);
        in_valid  = 1'b1;
        wb_sel    = sel;
        reg_write = rw;
        rd        = dst;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        wb_sel      = 2'd0;
        reg_write   = 1'b0;
        rd          = '0;
        alu_result  = '0;
        read_data   = '0;
        pc_plus4    = '0;
        load_size   = 2'd0;
        load_signed = 1'b0;
        mul_done    = 1'b0;
        mul_result  = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        drive_entry(2'd0, 1'b1, 5'd7);
        alu_result = 32'hDEAD_BEEF;
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
        checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf_wdata: got %h expected 0", rf_wdata); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d expected 0", rf_waddr); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid: got %b expected 0", fwd_valid); end
        checks++; if (fwd_addr !== 5'd0) begin errors++; $display("FAIL reset_fwd_addr: got %0d expected 0", fwd_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_source_select();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'h3;
        exp_data[1] = 32'h2;
        exp_data[2] = 32'h40;
        alu_result = 32'h3;
        read_data  = 32'h2;
        pc_plus4   = 32'h40;
        for (int i = 0; i < 3; i++) begin
            drive_entry(i[1:0], 1'b1, 5'd7);
            step();
            checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL src%0d_rf_we: got %b expected 1", i, rf_we); end
            checks++; if (rf_wdata !== exp_data[i]) begin errors++; $display("FAIL src%0d_rf_wdata: got %h expected %h", i, rf_wdata, exp_data[i]); end
            checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL src%0d_rf_waddr: got %0d expected 7", i, rf_waddr); end
            checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd7) begin errors++; $display("FAIL src%0d_fwd: got %b/%0d expected 1/7", i, fwd_valid, fwd_addr); end
        end
        // No accept: write enable drops, address and data hold
        in_valid = 1'b0;
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_rf_we: got %b expected 0", rf_we); end
        checks++; if (rf_wdata !== 32'h40 || rf_waddr !== 5'd7) begin errors++; $display("FAIL idle_hold: got %h/%0d expected 40/7", rf_wdata, rf_waddr); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL idle_fwd_valid: got %b expected 0", fwd_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_r0_suppress();
        alu_result = 32'h5;
        drive_entry(2'd0, 1'b1, 5'd0);
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_rf_we: got %b expected 0", rf_we); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL r0_fwd_valid: got %b expected 0", fwd_valid); end
        drive_entry(2'd0, 1'b0, 5'd1);
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL nowrite_rf_we: got %b expected 0", rf_we); end
        checks++; if (rf_waddr !== 5'd1) begin errors++; $display("FAIL nowrite_rf_waddr: got %0d expected 1", rf_waddr); end
        // Stray mul_done in RUN without a MUL accept
        in_valid   = 1'b0;
        mul_done   = 1'b1;
        mul_result = 32'h99;
        step();
        mul_done = 1'b0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL stray_mul_rf_we: got %b expected 0", rf_we); end
        checks++; if (rf_wdata !== 32'h5) begin errors++; $display("FAIL stray_mul_rf_wdata: got %h expected 5", rf_wdata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stray_mul_in_ready: got %b expected 1", in_ready); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_mul_wait();
        int stalled;
        stalled = 0;
        mul_done = 1'b0;
        drive_entry(2'd3, 1'b1, 5'd9);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_pre_in_ready: got %b expected 1", in_ready); end
        step();
        // A different entry is held on the input throughout the wait
        drive_entry(2'd0, 1'b1, 5'd4);
        alu_result = 32'h77;
        for (int i = 0; i < 3; i++) begin
            mul_done   = (i == 2);
            mul_result = 32'h12;
            if (in_ready === 1'b0) stalled++;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mul_wait%0d_stall: got %b expected 1", i, stall); end
            checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd9) begin errors++; $display("FAIL mul_wait%0d_fwd: got %b/%0d expected 1/9", i, fwd_valid, fwd_addr); end
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mul_wait%0d_rf_we: got %b expected 0", i, rf_we); end
            step();
        end
        mul_done = 1'b0;
        checks++; if (stalled != 3) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected 3", stalled); end
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL mul_done_rf_we: got %b expected 1", rf_we); end
        checks++; if (rf_wdata !== 32'h12) begin errors++; $display("FAIL mul_done_rf_wdata: got %h expected 12", rf_wdata); end
        checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL mul_done_rf_waddr: got %0d expected 9", rf_waddr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_done_in_ready: got %b expected 1", in_ready); end
        // The held entry transfers now that the stage is back in RUN
        step();
        in_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin errors++; $display("FAIL held_entry_write: got %b/%0d expected 1/4", rf_we, rf_waddr); end
        checks++; if (rf_wdata !== 32'h77) begin errors++; $display("FAIL held_entry_rf_wdata: got %h expected 77", rf_wdata); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        // Product available in the accept cycle: no stall, 1-cycle latency
        drive_entry(2'd3, 1'b1, 5'd10);
        mul_done   = 1'b1;
        mul_result = 32'hFFFF_FFFE;
        step();
        mul_done = 1'b0;
        in_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL same_cycle_mul: got %b/%h expected 1/fffffffe", rf_we, rf_wdata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL same_cycle_mul_in_ready: got %b expected 1", in_ready); end
        checks++; if (rf_waddr !== 5'd10) begin errors++; $display("FAIL same_cycle_mul_rf_waddr: got %0d expected 10", rf_waddr); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_in_wait();
        drive_entry(2'd3, 1'b1, 5'd11);
        mul_done = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstwait_entered: got %b expected 0", in_ready); end
        rst = 1'b1;
        step();
        rst        = 1'b0;
        mul_done   = 1'b1;
        mul_result = 32'h55;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstwait_in_ready: got %b expected 1", in_ready); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rstwait_fwd_valid: got %b expected 0", fwd_valid); end
        step();
        mul_done = 1'b0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstwait_late_mul_rf_we: got %b expected 0", rf_we); end
        checks++; if (rf_wdata !== 32'h0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL rstwait_late_mul_port: got %h/%0d expected 0/0", rf_wdata, rf_waddr); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_load_ext();
        logic [1:0]  size_v [4];
        logic        sgn_v  [4];
        logic [31:0] data_v [4];
        logic [31:0] exp_v  [4];
        size_v[0] = 2'd2; sgn_v[0] = 1'b1; data_v[0] = 32'h0000_0080;
        size_v[1] = 2'd2; sgn_v[1] = 1'b0; data_v[1] = 32'h0000_0080;
        size_v[2] = 2'd1; sgn_v[2] = 1'b1; data_v[2] = 32'h0000_0080;
        size_v[3] = 2'd1; sgn_v[3] = 1'b1; data_v[3] = 32'h0001_8000;
`ifdef LOAD_EXT_EN
        exp_v[0] = 32'hFFFF_FF80;
        exp_v[1] = 32'h0000_0080;
        exp_v[2] = 32'h0000_0080;
        exp_v[3] = 32'hFFFF_8000;
`else
        exp_v[0] = 32'h0000_0080;
        exp_v[1] = 32'h0000_0080;
        exp_v[2] = 32'h0000_0080;
        exp_v[3] = 32'h0001_8000;
`endif
        for (int i = 0; i < 4; i++) begin
            drive_entry(2'd1, 1'b1, 5'd3);
            load_size   = size_v[i];
            load_signed = sgn_v[i];
            read_data   = data_v[i];
            step();
            checks++; if (rf_wdata !== exp_v[i]) begin errors++; $display("FAIL load%0d_rf_wdata: got %h expected %h", i, rf_wdata, exp_v[i]); end
        end
        in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_source_select();
        test_r0_suppress();
        test_mul_wait();
        test_back_to_back();
        test_reset_in_wait();
        test_load_ext();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered, handshaked write-back stage for the 5-stage pipeline.
- Successor to the single-bit MemtoReg mux: four result sources (ALU, memory load, link address, Booth multiplier) selected per instruction.
- Holds the pipeline while a multi-cycle Booth product is outstanding.
- Drives the register-file write port one cycle after acceptance; exposes a same-cycle forwarding view for the hazard unit.

Parameters:
- DATA_W, 32, datapath width in bits; must be 16 or more and a multiple of 8.
- ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  MEM/WB entry valid
- in_ready  out  1  stage can accept an entry this cycle
- wb_sel  in  2  result source: 0 ALU, 1 MEM, 2 LINK, 3 MUL
- reg_write  in  1  entry writes the register file
- rd  in  ADDR_W  destination register
- alu_result  in  DATA_W  ALU result
- read_data  in  DATA_W  data-memory load data
- pc_plus4  in  DATA_W  link address
- load_size  in  2  0 word, 1 half, 2 byte; used only with LOAD_EXT_EN
- load_signed  in  1  sign-extend sub-word loads; used only with LOAD_EXT_EN
- mul_done  in  1  Booth multiplier result valid (1-cycle pulse)
- mul_result  in  DATA_W  low DATA_W bits of the product
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- fwd_valid  out  1  a write to fwd_addr is pending or occurring this cycle
- fwd_addr  out  ADDR_W  forwarding address
- stall  out  1  equals NOT in_ready

Behaviour:
- Reset: one clock, synchronous, active-high (fixed). On a cycle with rst=1, at the next edge the FSM enters RUN and rf_we, rf_waddr, rf_wdata, fwd_valid and fwd_addr all become 0. in_ready is 1 from the first post-reset cycle.
- FSM states: RUN, WAIT_MUL.
- in_ready = (state == RUN). An entry is accepted when in_valid && in_ready.
- Write qualification: write = reg_write && (rd != 0). Writes to r0 are always suppressed.
- Non-MUL entry accepted:
  - At the next edge: rf_we <= write, rf_waddr <= rd, rf_wdata <= selected source.
  - Latency is 1 cycle.
- MUL entry accepted with mul_done=1 in the same cycle: handled like a non-MUL entry, with data = mul_result.
- MUL entry accepted with mul_done=0:
  - Latch write and rd; go to WAIT_MUL.
  - rf_we <= 0 at the next edge.
- WAIT_MUL:
  - in_ready = 0.
  - On mul_done=1: rf_we <= latched write, rf_waddr <= latched rd, rf_wdata <= mul_result; go to RUN.
  - Otherwise rf_we <= 0 and hold.
- No accept in RUN: rf_we <= 0 at the next edge. rf_waddr and rf_wdata hold their last values.
- mul_done in RUN with no MUL entry being accepted: ignored, no write.
- Forwarding view:
  - In WAIT_MUL: fwd_valid = latched write, fwd_addr = latched rd. The hazard unit must stall any reader of that register.
  - Otherwise: fwd_valid = rf_we, fwd_addr = rf_waddr.
- Reset during WAIT_MUL: the pending write is dropped, the FSM returns to RUN, and a later mul_done is ignored.
- Widths: all data paths are DATA_W; no truncation or extension except under LOAD_EXT_EN.

Optional Feature:
- Macro name: LOAD_EXT_EN.
- Defined:
  - The MEM source is the extended load.
  - Half: read_data[15:0], sign- or zero-extended per load_signed.
  - Byte: read_data[7:0], likewise.
  - Word or load_size=3: read_data unchanged.
- Undefined:
  - The MEM source is read_data unchanged.
  - load_size and load_signed are unused.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> rf_we=0, rf_wdata=0, fwd_valid=0, in_ready=1 after release.
- Source select: wb_sel=0/1/2 with alu_result=3, read_data=2, pc_plus4=0x40, rd=7, reg_write=1 -> rf_wdata 3, 2, 0x40 on successive cycles, each one cycle after accept, rf_waddr=7.
- r0 suppression: rd=0, reg_write=1, alu_result=5 -> rf_we stays 0; same with rd=1, reg_write=0 -> rf_we stays 0.
- Multiplier wait: accept wb_sel=3, rd=9, mul_done=0, then mul_done=1 with mul_result=0x12 three cycles later:
  - in_ready=0 for exactly 3 cycles.
  - fwd_valid=1, fwd_addr=9 during the wait.
  - rf_we=1, rf_wdata=0x12 the cycle after mul_done.
  - A different entry held on in_valid is accepted only after the return to RUN.
- Same-cycle product: wb_sel=3, mul_done=1, mul_result=0xFFFF_FFFE -> rf_wdata=0xFFFF_FFFE after 1 cycle with no stall. Reset asserted mid-WAIT_MUL -> no write on a later mul_done.
- LOAD_EXT_EN: read_data=0x0000_0080 -> signed byte 0xFFFF_FF80, unsigned byte 0x80, signed half 0x0000_0080. Without the macro -> 0x0000_0080 in all three cases.
